// File: rtl/ollar_pkg.sv
// -----------------------------------------------------------------------------
// ollar_pkg
// Shared types and constants for the OLLAR instruction-fetch front end.
//   fetch_state_t    : FETCH (normal fetching) / FLUSH (draining stale responses)
//   OLLAR_XLEN       : default address/instruction width
//   OLLAR_INSN_BYTES : default PC increment per fetch
//   ollar_cnt_width  : width of a counter able to hold 0..depth inclusive
// -----------------------------------------------------------------------------
package ollar_pkg;

    localparam int OLLAR_XLEN       = 32;
    localparam int OLLAR_INSN_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    function automatic int ollar_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ollar_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// ollar_fetch_queue_if
// Bundles the memory fetch port, the redirect strobe and the decode handshake
// of the fetch front end.
//   master : the fetch queue (drives MEM_ADDRESS/MEM_REQUEST and the IR head)
//   slave  : the environment (memory, branch unit and decode stage)
// -----------------------------------------------------------------------------
interface ollar_fetch_queue_if
    import ollar_pkg::*;
#(
    parameter int XLEN = OLLAR_XLEN
);
    logic [XLEN-1:0] MEM_ADDRESS_PIN;
    logic            MEM_REQUEST_PIN;
    logic            MEM_GRANT_PIN;
    logic [XLEN-1:0] MEM_INPUT_PIN;
    logic            MEM_VALID_PIN;
    logic            REDIRECT_PIN;
    logic [XLEN-1:0] REDIRECT_ADDRESS_PIN;
    logic            IR_VALID_PIN;
    logic [XLEN-1:0] IR_PIN;
    logic [XLEN-1:0] IR_PC_PIN;
    logic            IR_READY_PIN;

    modport master (
        output MEM_ADDRESS_PIN, MEM_REQUEST_PIN, IR_VALID_PIN, IR_PIN, IR_PC_PIN,
        input  MEM_GRANT_PIN, MEM_INPUT_PIN, MEM_VALID_PIN,
        input  REDIRECT_PIN, REDIRECT_ADDRESS_PIN, IR_READY_PIN
    );

    modport slave (
        input  MEM_ADDRESS_PIN, MEM_REQUEST_PIN, IR_VALID_PIN, IR_PIN, IR_PC_PIN,
        output MEM_GRANT_PIN, MEM_INPUT_PIN, MEM_VALID_PIN,
        output REDIRECT_PIN, REDIRECT_ADDRESS_PIN, IR_READY_PIN
    );
endinterface

// File: rtl/ollar_sync_fifo.sv
// -----------------------------------------------------------------------------
// ollar_sync_fifo
// DEPTH x WIDTH synchronous FIFO with synchronous clear. The head entry is read
// straight out of the storage flops, so o_rdata is a registered value.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (storage zeroed)
//   i_push/i_wdata : write one entry (ignored when full unless popping too)
//   i_pop          : drop the head entry (ignored when empty)
//   i_clear        : empty the FIFO, wins over push/pop
//   o_rdata        : head entry
//   o_count        : occupancy 0..DEPTH
//   o_full/o_empty : occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module ollar_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == CW'(0));
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO may still accept a push when the head leaves in the same cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage, pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end
endmodule

// File: rtl/ollar_sync_fifo_chk.sv
// -----------------------------------------------------------------------------
// ollar_sync_fifo_chk
// Protocol checker for ollar_sync_fifo, attached with bind.
//   i_clk, i_rst_n : clock and reset of the checked FIFO
//   i_push, i_pop  : FIFO requests
//   i_full         : FIFO full flag
// The fetch front end caps requests so a push never lands in a full queue
// unless the head is popped in the same cycle.
// -----------------------------------------------------------------------------
module ollar_sync_fifo_chk (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_push,
    input logic i_pop,
    input logic i_full
);
    a_no_overflow: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) !(i_push && i_full && !i_pop)
    );
endmodule

// File: rtl/ollar_fetch_queue.sv
// -----------------------------------------------------------------------------
// ollar_fetch_queue
// Instruction-fetch front end: owns the PC, issues pipelined fetches, buffers
// returned words in a DEPTH-entry queue and presents {insn, pc} to decode.
// A redirect reloads the PC, clears the queue and discards every response
// still in flight (FLUSH state) before fetching resumes.
//   CLOCK_PIN : system clock, rising edge
//   RESET_PIN : asynchronous active-low reset
//   bus       : ollar_fetch_queue_if.master (memory port, redirect, IR handshake)
// Configuration macro OLLAR_FETCH_BYPASS_EN: when defined, a response arriving
// while the queue is empty is presented to decode combinationally in the same
// cycle and is not written if decode takes it. Undefined: the queue adds one
// cycle and there is no MEM_INPUT -> IR path.
// -----------------------------------------------------------------------------
module ollar_fetch_queue
    import ollar_pkg::*;
#(
    parameter int              XLEN         = OLLAR_XLEN,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSN_BYTES   = OLLAR_INSN_BYTES
) (
    input logic                 CLOCK_PIN,
    input logic                 RESET_PIN,
    ollar_fetch_queue_if.master bus
);
    localparam int              CW      = ollar_cnt_width(DEPTH);
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(INSN_BYTES);

    fetch_state_t     r_state, w_state_next;
    logic [XLEN-1:0]  r_pc, w_pc_next;
    logic [XLEN-1:0]  r_resp_pc, w_resp_pc_next;
    logic [CW-1:0]    r_inflight, w_inflight_next;
    logic [CW-1:0]    r_discard, w_discard_next;

    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;
    logic [2*XLEN-1:0] w_head;
    logic             w_req;
    logic             w_grant;
    logic             w_fresh;
    logic             w_byp_take;
    logic             w_push;
    logic             w_pop;

    // Request only while fetching, not redirecting, and while every word that
    // could come back still has a queue slot waiting for it.
    assign w_req   = RESET_PIN && (r_state == FETCH) && !bus.REDIRECT_PIN && !w_full
                     && (({1'b0, w_count} + {1'b0, r_inflight}) < DEPTH_W);
    assign w_grant = w_req && bus.MEM_GRANT_PIN;
    // A response that belongs to the current instruction stream
    assign w_fresh = (r_state == FETCH) && bus.MEM_VALID_PIN && !bus.REDIRECT_PIN;
    assign w_pop   = !w_empty && bus.IR_READY_PIN && !bus.REDIRECT_PIN;
    assign w_push  = w_fresh && !w_byp_take;

    assign bus.MEM_REQUEST_PIN = w_req;
    assign bus.MEM_ADDRESS_PIN = r_pc;

`ifdef OLLAR_FETCH_BYPASS_EN
    logic w_byp;
    assign w_byp            = w_fresh && w_empty;
    assign w_byp_take       = w_byp && bus.IR_READY_PIN;
    assign bus.IR_VALID_PIN = !w_empty || w_byp;
    assign bus.IR_PIN       = w_byp ? bus.MEM_INPUT_PIN : w_head[2*XLEN-1:XLEN];
    assign bus.IR_PC_PIN    = w_byp ? r_resp_pc : w_head[XLEN-1:0];
`else
    assign w_byp_take       = 1'b0;
    assign bus.IR_VALID_PIN = !w_empty;
    assign bus.IR_PIN       = w_head[2*XLEN-1:XLEN];
    assign bus.IR_PC_PIN    = w_head[XLEN-1:0];
`endif

    ollar_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .i_clk   (CLOCK_PIN),
        .i_rst_n (RESET_PIN),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.REDIRECT_PIN),
        .i_wdata ({bus.MEM_INPUT_PIN, r_resp_pc}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-state logic for the FSM, PCs and in-flight/discard counters
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_resp_pc_next  = r_resp_pc;
        w_inflight_next = r_inflight;
        w_discard_next  = r_discard;
        if (bus.REDIRECT_PIN) begin
            w_pc_next       = bus.REDIRECT_ADDRESS_PIN;
            w_resp_pc_next  = bus.REDIRECT_ADDRESS_PIN;
            w_inflight_next = '0;
            // Everything still owed by memory becomes stale, minus the
            // response that is being dropped right now.
            w_discard_next  = r_inflight + r_discard + CW'(w_grant) - CW'(bus.MEM_VALID_PIN);
            if (r_state == FETCH) begin
                w_state_next = (w_discard_next != '0) ? FLUSH : FETCH;
            end else begin
                w_state_next = FLUSH;
            end
        end else begin
            if (w_grant) begin
                w_pc_next = r_pc + STEP;
            end else begin
                w_pc_next = r_pc;
            end
            case (r_state)
                FETCH: begin
                    w_inflight_next = r_inflight + CW'(w_grant) - CW'(bus.MEM_VALID_PIN);
                    if (bus.MEM_VALID_PIN) begin
                        w_resp_pc_next = r_resp_pc + STEP;
                    end else begin
                        w_resp_pc_next = r_resp_pc;
                    end
                end
                FLUSH: begin
                    if (bus.MEM_VALID_PIN && (r_discard != '0)) begin
                        w_discard_next = r_discard - CW'(1);
                    end else begin
                        w_discard_next = r_discard;
                    end
                    w_state_next = (w_discard_next == '0) ? FETCH : FLUSH;
                end
                default: begin
                    w_state_next = FETCH;
                end
            endcase
        end
    end

    // FSM state, PC and counter registers
    always_ff @(posedge CLOCK_PIN or negedge RESET_PIN) begin
        if (!RESET_PIN) begin
            r_state    <= FETCH;
            r_pc       <= RESET_VECTOR;
            r_resp_pc  <= RESET_VECTOR;
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_resp_pc  <= w_resp_pc_next;
            r_inflight <= w_inflight_next;
            r_discard  <= w_discard_next;
        end
    end
endmodule

// File: tb/tb_ollar_fetch_queue.sv
module tb_ollar_fetch_queue;
    import ollar_pkg::*;

    localparam int DEPTH = 4;
`ifdef OLLAR_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          rdy;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ollar_fetch_queue_if #(.XLEN(32)) bus ();

    ollar_fetch_queue #(
        .XLEN(32), .DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000), .INSN_BYTES(4)
    ) dut (
        .CLOCK_PIN (clk),
        .RESET_PIN (rst_n),
        .bus       (bus)
    );

    bind ollar_sync_fifo ollar_sync_fifo_chk u_fifo_chk (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(i_push), .i_pop(i_pop), .i_full(o_full)
    );

    // Reference model: memory request list tagged with the stream epoch, and
    // the list of instruction addresses decode is still owed.
    req_t        pend[$];
    logic [31:0] mq_pc[$];
    int          epoch, cyc, checks, fails;
    logic [31:0] m_pc;
    bit          m_flush;
    int          k_grant, k_valid, k_ready, k_redir, k_lat_min, k_lat_max;
    bit          f_redir;
    logic [31:0] f_addr;
    int          n_grant, n_pop, n_drop;
    bit          seen_pop;
    logic [31:0] first_pop_pc;
    bit          redir_now;
    bit          exp_req, exp_valid;
    logic [31:0] exp_addr, exp_ir, exp_pc;
    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_ir, obs_pc;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic set_knobs(input int g, input int v, input int r, input int rd,
                             input int lmin, input int lmax);
        k_grant = g; k_valid = v; k_ready = r; k_redir = rd; k_lat_min = lmin; k_lat_max = lmax;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.MEM_GRANT_PIN = 1'b0; bus.MEM_VALID_PIN = 1'b0; bus.MEM_INPUT_PIN = 32'h0;
        bus.REDIRECT_PIN = 1'b0; bus.REDIRECT_ADDRESS_PIN = 32'h0; bus.IR_READY_PIN = 1'b0;
        pend.delete(); mq_pc.delete();
        m_pc = 32'h0; m_flush = 1'b0; epoch = 0; f_redir = 1'b0;
        n_grant = 0; n_pop = 0; n_drop = 0; seen_pop = 1'b0;
        set_knobs(0, 0, 0, 0, 1, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock of stimulus, expectation and model update
    task automatic model_cycle();
        bit   vld, fresh, accepted, pop, take;
        int   stale;
        req_t head;
        @(negedge clk);
        redir_now = f_redir || (int'($urandom_range(99)) < k_redir);
        bus.REDIRECT_PIN = redir_now;
        bus.REDIRECT_ADDRESS_PIN = f_redir ? f_addr : ($urandom() & 32'hFFFF_FFFC);
        f_redir = 1'b0;
        bus.IR_READY_PIN  = int'($urandom_range(99)) < k_ready;
        bus.MEM_GRANT_PIN = int'($urandom_range(99)) < k_grant;
        vld = (pend.size() > 0) && (pend[0].rdy <= cyc) && (int'($urandom_range(99)) < k_valid);
        if (vld) head = pend[0];
        bus.MEM_VALID_PIN = vld;
        bus.MEM_INPUT_PIN = vld ? memfn(head.addr) : $urandom();
        #1;
        exp_addr  = m_pc;
        exp_req   = !m_flush && !redir_now && ((mq_pc.size() + pend.size()) < DEPTH);
        fresh     = vld && (head.epoch == epoch) && !redir_now;
        exp_valid = mq_pc.size() > 0;
        exp_pc    = exp_valid ? mq_pc[0] : 32'h0;
        take      = 1'b0;
        if (BYP && !exp_valid && fresh) begin
            exp_valid = 1'b1;
            exp_pc    = head.addr;
            take      = bus.IR_READY_PIN;
        end
        exp_ir    = memfn(exp_pc);
        obs_req   = bus.MEM_REQUEST_PIN;
        obs_addr  = bus.MEM_ADDRESS_PIN;
        obs_valid = bus.IR_VALID_PIN;
        obs_ir    = bus.IR_PIN;
        obs_pc    = bus.IR_PC_PIN;
        accepted  = obs_req && bus.MEM_GRANT_PIN;
        pop       = exp_valid && bus.IR_READY_PIN && !redir_now;
        if (vld) begin
            void'(pend.pop_front());
            if (!fresh) n_drop++;
        end
        if (accepted) begin
            pend.push_back('{addr: m_pc, epoch: epoch,
                             rdy: cyc + int'($urandom_range(k_lat_max, k_lat_min))});
            m_pc += 32'd4;
            n_grant++;
        end
        if (pop) begin
            n_pop++;
            if (!seen_pop) begin seen_pop = 1'b1; first_pop_pc = exp_pc; end
        end
        if (redir_now) begin
            mq_pc.delete();
            epoch++;
            m_pc = bus.REDIRECT_ADDRESS_PIN;
        end else begin
            if (pop && mq_pc.size() > 0) void'(mq_pc.pop_front());
            if (fresh && !take) mq_pc.push_back(head.addr);
        end
        stale = 0;
        foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
        m_flush = redir_now ? (m_flush || stale > 0) : (stale > 0);
        cyc++;
    endtask

    // Runs n model cycles comparing the DUT against the model every cycle
    task automatic run_checked(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            model_cycle();
            checks++;
            if (obs_req !== exp_req) begin
                fails++; $display("FAIL %s mem_request cyc=%0d got %b exp %b", tag, cyc, obs_req, exp_req);
            end
            checks++;
            if (obs_addr !== exp_addr) begin
                fails++; $display("FAIL %s mem_address cyc=%0d got %h exp %h", tag, cyc, obs_addr, exp_addr);
            end
            checks++;
            if (obs_valid !== exp_valid) begin
                fails++; $display("FAIL %s ir_valid cyc=%0d got %b exp %b", tag, cyc, obs_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (obs_pc !== exp_pc || obs_ir !== exp_ir) begin
                    fails++;
                    $display("FAIL %s ir_head cyc=%0d got %h/%h exp %h/%h", tag, cyc, obs_pc, obs_ir, exp_pc, exp_ir);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.MEM_REQUEST_PIN !== 1'b0 || bus.MEM_ADDRESS_PIN !== 32'h0) begin
            fails++; $display("FAIL reset_mem got req=%b addr=%h exp 0/00000000", bus.MEM_REQUEST_PIN, bus.MEM_ADDRESS_PIN);
        end
        checks++;
        if (bus.IR_VALID_PIN !== 1'b0 || bus.IR_PIN !== 32'h0 || bus.IR_PC_PIN !== 32'h0) begin
            fails++; $display("FAIL reset_ir got v=%b ir=%h pc=%h exp 0/0/0", bus.IR_VALID_PIN, bus.IR_PIN, bus.IR_PC_PIN);
        end
    endtask

    task automatic test_stream();
        do_reset();
        set_knobs(100, 100, 100, 0, 1, 1);
        run_checked("stream", 40);
        checks++;
        if (n_pop < 30 || first_pop_pc !== 32'h0) begin
            fails++; $display("FAIL stream_progress got pops=%0d first=%h exp >=30/00000000", n_pop, first_pop_pc);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_knobs(100, 100, 0, 0, 1, 3);
        run_checked("backpressure", 20);
        checks++;
        if (n_grant != DEPTH) begin
            fails++; $display("FAIL bp_grants got %0d exp %0d", n_grant, DEPTH);
        end
        checks++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_pc !== 32'h0) begin
            fails++; $display("FAIL bp_hold got req=%b v=%b pc=%h exp 0/1/00000000", obs_req, obs_valid, obs_pc);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.IR_VALID_PIN !== 1'b0 || bus.IR_PC_PIN !== 32'h0 || bus.MEM_REQUEST_PIN !== 1'b0) begin
            fails++; $display("FAIL midburst_reset got v=%b pc=%h req=%b exp 0/0/0", bus.IR_VALID_PIN, bus.IR_PC_PIN, bus.MEM_REQUEST_PIN);
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        set_knobs(100, 0, 0, 0, 1, 1);
        run_checked("flush_fill", 2);
        checks++;
        if (n_grant != 2) begin
            fails++; $display("FAIL flush_inflight got %0d exp 2", n_grant);
        end
        n_drop = 0; seen_pop = 1'b0;
        f_redir = 1'b1; f_addr = 32'h0000_0100;
        run_checked("flush_redirect", 1);
        set_knobs(100, 100, 100, 0, 1, 1);
        run_checked("flush_after", 1);
        checks++;
        if (obs_valid !== 1'b0) begin
            fails++; $display("FAIL flush_empty got %b exp 0", obs_valid);
        end
        run_checked("flush_drain", 15);
        checks++;
        if (n_drop != 2 || !seen_pop || first_pop_pc !== 32'h0000_0100) begin
            fails++; $display("FAIL flush_result got drops=%0d first=%h exp 2/00000100", n_drop, first_pop_pc);
        end
    endtask

    task automatic test_redirect_collide();
        do_reset();
        set_knobs(100, 100, 0, 0, 2, 2);
        run_checked("collide_fill", 3);
        n_drop = 0; seen_pop = 1'b0;
        f_redir = 1'b1; f_addr = 32'h0000_0200;
        run_checked("collide_redirect", 1);
        set_knobs(100, 100, 100, 0, 2, 2);
        run_checked("collide_drain", 16);
        checks++;
        if (n_drop != 2 || !seen_pop || first_pop_pc !== 32'h0000_0200) begin
            fails++; $display("FAIL collide_result got drops=%0d first=%h exp 2/00000200", n_drop, first_pop_pc);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        set_knobs(0, 100, 100, 0, 1, 1);
        f_redir = 1'b1; f_addr = 32'hFFFF_FFFC;
        run_checked("wrap_redirect", 1);
        k_grant = 100;
        run_checked("wrap_grant", 1);
        checks++;
        if (obs_addr !== 32'hFFFF_FFFC || obs_req !== 1'b1) begin
            fails++; $display("FAIL wrap_first got %h/%b exp fffffffc/1", obs_addr, obs_req);
        end
        run_checked("wrap_next", 1);
        checks++;
        if (obs_addr !== 32'h0000_0000) begin
            fails++; $display("FAIL wrap_next got %h exp 00000000", obs_addr);
        end
        run_checked("wrap_run", 10);
    endtask

    task automatic test_bypass_latency();
        do_reset();
        set_knobs(100, 0, 100, 0, 1, 1);
        run_checked("lat_grant", 1);
        set_knobs(0, 100, 100, 0, 1, 1);
        run_checked("lat_resp", 1);
        checks++;
        if (obs_valid !== BYP) begin
            fails++; $display("FAIL lat_same_cycle got %b exp %b", obs_valid, BYP);
        end
        run_checked("lat_next", 1);
        checks++;
        if (obs_valid !== !BYP) begin
            fails++; $display("FAIL lat_next_cycle got %b exp %b", obs_valid, !BYP);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int ph = 0; ph < 5; ph++) begin
            set_knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                      int'($urandom_range(100, 10)), int'($urandom_range(6, 1)), 1,
                      int'($urandom_range(5, 1)));
            run_checked("random", 600);
        end
        checks++;
        if (n_pop < 100) begin
            fails++; $display("FAIL random_progress got %0d pops exp >=100", n_pop);
        end
    endtask

    initial begin
        checks = 0; fails = 0; cyc = 0;
        bus.MEM_GRANT_PIN = 1'b0; bus.MEM_VALID_PIN = 1'b0; bus.MEM_INPUT_PIN = 32'h0;
        bus.REDIRECT_PIN = 1'b0; bus.REDIRECT_ADDRESS_PIN = 32'h0; bus.IR_READY_PIN = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_collide();
        test_pc_wrap();
        test_bypass_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
